// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_SHL = 4'd7,
    OP_SAR = 4'd8,
    OP_ROL = 4'd9,
    OP_ROR = 4'd10,
    OP_MUL = 4'd11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] mk_flags(input logic n, input logic z,
                                          input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bus of the sequential ALU. A request is taken on an edge with
// in_valid & in_ready; a result is held stable while out_valid until an edge with out_ready.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_hi;
  logic [3:0]       flags;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, r, r_hi, flags, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, r, r_hi, flags, err
  );
endinterface

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor; subtraction adds the inverted operand
// so carry-out reads as "no borrow".
module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH:0]   w_full;

  assign w_bx   = i_sub ? ~i_b : i_b;
  assign w_full = {1'b0, i_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, i_cin};
  assign o_sum  = w_full[WIDTH-1:0];
  assign o_cout = w_full[WIDTH];
  // Overflow: both addends share a sign that the sum does not.
  assign o_ovf  = (i_a[WIDTH-1] == w_bx[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-pass add/sub/logic, bit-serial shifts and rotates, and a
// WIDTH-cycle shift-add multiplier, all behind the seq_alu_if handshake.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus,
  output state_t   o_state
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  state_t           r_state, w_next;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_acc, r_mcand, r_hi_acc;
  logic [CW-1:0]    r_cnt, w_shift_n;
  logic [WIDTH-1:0] r_res, r_res_hi, w_res;
  logic [3:0]       r_flags, w_flags;
  logic             r_err, w_err;
  logic             w_is_shift, w_is_mul, w_accept, w_last, w_direct;
  logic             w_as_sub, w_as_cin, w_as_cout, w_as_ovf;
  logic [WIDTH-1:0] w_as_sum;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_sh_c;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_lo, w_mul_hi;

  assign w_is_shift = (bus.op >= OP_SHL) && (bus.op <= OP_ROR);
  assign w_is_mul   = (bus.op == OP_MUL);
  assign w_accept   = bus.in_valid && (r_state == ST_IDLE);
  assign w_last     = (r_cnt == CW'(1));
  assign w_direct   = !w_is_mul && !(w_is_shift && (w_shift_n != '0));

  // ADC/SBC chain from the carry held in the flag register.
  assign w_as_sub = (bus.op == OP_SUB) || (bus.op == OP_SBC);
  assign w_as_cin = ((bus.op == OP_ADC) || (bus.op == OP_SBC)) ? r_flags[FLAG_C]
                                                                : (bus.op == OP_SUB);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a   (bus.a),
    .i_b   (bus.b),
    .i_sub (w_as_sub),
    .i_cin (w_as_cin),
    .o_sum (w_as_sum),
    .o_cout(w_as_cout),
    .o_ovf (w_as_ovf)
  );

  always_comb begin
    w_shift_n = '0;
    case (bus.op)
      OP_SHL, OP_SAR: w_shift_n = (bus.b >= W_VAL) ? CW'(WIDTH) : CW'(bus.b);
      OP_ROL, OP_ROR: w_shift_n = CW'(bus.b % W_VAL);
      default:        w_shift_n = '0;
    endcase
  end

  always_comb begin
    w_res   = '0;
    w_flags = r_flags;
    w_err   = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        w_res           = w_as_sum;
        w_flags[FLAG_C] = w_as_cout;
        w_flags[FLAG_V] = w_as_ovf;
      end
      OP_AND: begin w_res = bus.a & bus.b; w_flags[FLAG_C] = 1'b0; w_flags[FLAG_V] = 1'b0; end
      OP_OR:  begin w_res = bus.a | bus.b; w_flags[FLAG_C] = 1'b0; w_flags[FLAG_V] = 1'b0; end
      OP_XOR: begin w_res = bus.a ^ bus.b; w_flags[FLAG_C] = 1'b0; w_flags[FLAG_V] = 1'b0; end
      OP_SHL, OP_SAR, OP_ROL, OP_ROR: w_res = bus.a;
      OP_MUL: w_res = '0;
      default: w_err = 1'b1;
    endcase
    if (!w_err) begin
      w_flags[FLAG_N] = w_res[WIDTH-1];
      w_flags[FLAG_Z] = (w_res == '0);
    end
  end

  always_comb begin
    w_sh_next = r_acc;
    w_sh_c    = 1'b0;
    case (r_op)
      OP_SHL: begin w_sh_c = r_acc[WIDTH-1]; w_sh_next = {r_acc[WIDTH-2:0], 1'b0}; end
      OP_SAR: begin w_sh_c = r_acc[0];       w_sh_next = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]}; end
      OP_ROL: begin w_sh_c = r_acc[WIDTH-1]; w_sh_next = {r_acc[WIDTH-2:0], r_acc[WIDTH-1]}; end
      OP_ROR: begin w_sh_c = r_acc[0];       w_sh_next = {r_acc[0], r_acc[WIDTH-1:1]}; end
      default: begin w_sh_c = 1'b0; w_sh_next = r_acc; end
    endcase
  end

  // Multiplier in r_acc shifts out LSB-first while product bits shift in from the top.
  assign w_mul_sum = {1'b0, r_hi_acc} + {1'b0, r_mcand & {WIDTH{r_acc[0]}}};
  assign w_mul_lo  = {w_mul_sum[0], r_acc[WIDTH-1:1]};
  assign w_mul_hi  = w_mul_sum[WIDTH:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (w_is_mul)      w_next = ST_MUL;
          else if (w_direct) w_next = ST_DONE;
          else               w_next = ST_SHIFT;
        end
      end
      ST_SHIFT, ST_MUL: if (w_last) w_next = ST_DONE;
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_hi_acc <= '0;
      r_cnt    <= '0;
      r_res    <= '0;
      r_res_hi <= '0;
      r_flags  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op     <= bus.op;
          r_mcand  <= bus.a;
          r_hi_acc <= '0;
          r_acc    <= w_is_mul ? bus.b : bus.a;
          r_cnt    <= w_is_mul ? CW'(WIDTH) : w_shift_n;
          if (w_direct) begin
            r_res    <= w_res;
            r_res_hi <= '0;
            r_flags  <= w_flags;
            r_err    <= w_err;
          end
        end
        ST_SHIFT: begin
          r_acc <= w_sh_next;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_res    <= w_sh_next;
            r_res_hi <= '0;
            r_flags  <= mk_flags(w_sh_next[WIDTH-1], w_sh_next == '0, w_sh_c, 1'b0);
            r_err    <= 1'b0;
          end
        end
        ST_MUL: begin
          r_acc    <= w_mul_lo;
          r_hi_acc <= w_mul_hi;
          r_cnt    <= r_cnt - CW'(1);
          if (w_last) begin
            r_res    <= w_mul_lo;
            r_res_hi <= w_mul_hi;
            r_flags  <= mk_flags(w_mul_lo[WIDTH-1], {w_mul_hi, w_mul_lo} == '0,
                                 w_mul_hi != '0, 1'b0);
            r_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.r     = r_res;
  assign bus.r_hi  = r_res_hi;
  assign bus.flags = r_flags;
  assign bus.err   = r_err;
  assign o_state   = r_state;
endmodule
